neuron_accumulate_activate: RTL and testbench
=============================================

NEURON_ACCUMULATE_ACTIVATE -- requirements
Module: neuron_accumulate_activate

Interface
REQ-001 SHALL have parameter SUM_WIDTH, default 16: width of signed two's-complement partial sums, bias and activation.
REQ-002 SHALL have parameter ACC_WIDTH, default 24: internal accumulator width, at least SUM_WIDTH+clog2(MAX_CHUNKS+1).
REQ-003 SHALL have parameter MAX_CHUNKS, default 16: maximum partial sums accepted per neuron.
REQ-004 SHALL have parameter RELU_ENABLE, default 1: 1 applies ReLU after saturation, 0 passes the saturated value.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on rising edge.
REQ-006 SHALL have port reset_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port partial_sum_in, input, SUM_WIDTH: signed partial sum from the upstream adder chain.
REQ-008 SHALL have port partial_valid_in, input, 1 bit: partial_sum_in is valid.
REQ-009 SHALL have port partial_last_in, input, 1 bit: current beat is the neuron's final chunk.
REQ-010 SHALL have port partial_ready_out, output, 1 bit: block can accept a beat.
REQ-011 SHALL have port bias_in, input, SUM_WIDTH: signed neuron bias, sampled on the first beat.
REQ-012 SHALL have port activation_out, output, SUM_WIDTH: signed neuron result.
REQ-013 SHALL have port activation_valid_out, output, 1 bit: activation_out is valid.
REQ-014 SHALL have port activation_ready_in, input, 1 bit: downstream accepts activation_out.
REQ-015 SHALL have port chunk_overflow_out, output, 1 bit: sticky error flag.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, OUTPUT.
REQ-017 Beat accepted when partial_valid_in && partial_ready_out at a rising edge.
REQ-018 partial_ready_out SHALL be combinational: 1 in IDLE/ACCUM, 0 in OUTPUT.
REQ-019 Beat accepted in IDLE: acc <= sext(bias_in) + sext(partial_sum_in), chunk_count <= 1; non-last beat moves to ACCUM.
REQ-020 Beat accepted in ACCUM: acc <= acc + sext(partial_sum_in), chunk_count increments; no wrap possible within ACC_WIDTH.
REQ-021 Beat accepted with partial_last_in=1, in IDLE or ACCUM: final sum (acc_next) clamped to [-2^(SUM_WIDTH-1), 2^(SUM_WIDTH-1)-1]; if RELU_ENABLE, negatives forced to 0; result registered into activation_out; state to OUTPUT; activation_valid_out=1 after that same edge (1-cycle latency).
REQ-022 Beat accepted as the MAX_CHUNKS-th beat with partial_last_in=0 SHALL be treated as last and set chunk_overflow_out=1 until reset.
REQ-023 In OUTPUT, activation_out and activation_valid_out SHALL hold stable while activation_ready_in=0; partial_valid_in ignored.
REQ-024 In OUTPUT with activation_ready_in=1: activation_valid_out <= 0, state <= IDLE; no beat accepted in that cycle.
REQ-025 Cycles with partial_valid_in=0 in ACCUM SHALL leave acc and chunk_count unchanged.

Reset
REQ-026 On reset_ni=0, immediately and independent of clk_in: state IDLE, acc 0, chunk_count 0, activation_out 0, activation_valid_out 0, chunk_overflow_out 0; partial_ready_out therefore 1.
REQ-027 Reset during ACCUM or OUTPUT SHALL discard partial results; no activation emitted for that neuron.

Structure
REQ-028 Package nn_pkg SHALL hold SUM_WIDTH/ACC_WIDTH defaults and the FSM state enum typedef.
REQ-029 Saturation plus ReLU SHALL be a combinational sub-module saturate_relu (ACC_WIDTH in, SUM_WIDTH out, RELU_ENABLE parameter).

Verification
REQ-030 bias 5; beats 10, 20, 30(last) -> activation_out=65, valid one cycle after last beat; chunk_overflow_out=0.
REQ-031 bias 0; beats -100, 40(last) -> activation_out=0 (ReLU); RELU_ENABLE=0 -> -60 (0xFFC4).
REQ-032 bias 0x7000; beats 0x7000, 0x7000(last) -> activation_out=0x7FFF (saturated).
REQ-033 After last beat, activation_ready_in=0 for 5 cycles with partial_valid_in=1 -> output stable, partial_ready_out=0, acc unchanged; ready=1 -> IDLE next cycle.
REQ-034 bias 0; 16 beats of 1, partial_last_in never set -> activation_out=16, chunk_overflow_out=1 until reset.
REQ-035 reset_ni low for one cycle after two beats of 50 in ACCUM -> all outputs 0; new neuron bias 0, beat 7(last) -> activation_out=7.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared defaults and FSM state type for the neuron accumulate/activate datapath.
package nn_pkg;

  localparam int DEFAULT_SUM_WIDTH = 16;
  localparam int DEFAULT_ACC_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

endpackage

// File: rtl/saturate_relu.sv
// Clamps a wide signed accumulator into the narrow activation range,
// then optionally applies ReLU to the clamped value.
module saturate_relu #(
  parameter int SUM_WIDTH   = 16,
  parameter int ACC_WIDTH   = 24,
  parameter int RELU_ENABLE = 1
) (
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  output logic        [SUM_WIDTH-1:0] result_out
);

  // Range limits of the narrow type, sign-extended to accumulator width
  localparam logic signed [ACC_WIDTH-1:0] MAX_VAL =
    {{(ACC_WIDTH-SUM_WIDTH+1){1'b0}}, {(SUM_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_VAL =
    {{(ACC_WIDTH-SUM_WIDTH+1){1'b1}}, {(SUM_WIDTH-1){1'b0}}};

  logic [SUM_WIDTH-1:0] clamped;

  always_comb begin
    clamped = acc_in[SUM_WIDTH-1:0];
    if (acc_in > MAX_VAL) begin
      clamped = MAX_VAL[SUM_WIDTH-1:0];
    end else if (acc_in < MIN_VAL) begin
      clamped = MIN_VAL[SUM_WIDTH-1:0];
    end
    result_out = clamped;
    if ((RELU_ENABLE != 0) && clamped[SUM_WIDTH-1]) begin
      result_out = '0;
    end
  end

endmodule

// File: rtl/neuron_accumulate_activate.sv
// Accumulates bias plus a stream of partial sums for one neuron, then
// presents the saturated (optionally ReLU'd) activation with a valid/ready handshake.
module neuron_accumulate_activate
  import nn_pkg::*;
#(
  parameter int SUM_WIDTH   = DEFAULT_SUM_WIDTH,
  parameter int ACC_WIDTH   = DEFAULT_ACC_WIDTH,
  parameter int MAX_CHUNKS  = 16,
  parameter int RELU_ENABLE = 1
) (
  input  logic                 clk_in,
  input  logic                 reset_ni,
  input  logic [SUM_WIDTH-1:0] partial_sum_in,
  input  logic                 partial_valid_in,
  input  logic                 partial_last_in,
  output logic                 partial_ready_out,
  input  logic [SUM_WIDTH-1:0] bias_in,
  output logic [SUM_WIDTH-1:0] activation_out,
  output logic                 activation_valid_out,
  input  logic                 activation_ready_in,
  output logic                 chunk_overflow_out
);

  localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

  state_t state, state_next;

  logic signed [ACC_WIDTH-1:0] acc, acc_next, acc_base, sum_ext, bias_ext;
  logic [CNT_W-1:0]            chunk_count, count_next;
  logic                        beat_accept, at_max, finish;
  logic [SUM_WIDTH-1:0]        sat_result;

  assign partial_ready_out = (state != OUTPUT);
  assign beat_accept       = partial_valid_in && partial_ready_out;

  assign sum_ext  = {{(ACC_WIDTH-SUM_WIDTH){partial_sum_in[SUM_WIDTH-1]}}, partial_sum_in};
  assign bias_ext = {{(ACC_WIDTH-SUM_WIDTH){bias_in[SUM_WIDTH-1]}}, bias_in};

  // The first beat of a neuron starts from the bias instead of the stale accumulator
  assign acc_base   = (state == IDLE) ? bias_ext : acc;
  assign acc_next   = acc_base + sum_ext;
  assign count_next = (state == IDLE) ? CNT_W'(1) : chunk_count + CNT_W'(1);
  assign at_max     = (count_next == CNT_W'(MAX_CHUNKS));
  assign finish     = beat_accept && (partial_last_in || at_max);

  saturate_relu #(
    .SUM_WIDTH  (SUM_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .RELU_ENABLE(RELU_ENABLE)
  ) u_saturate_relu (
    .acc_in    (acc_next),
    .result_out(sat_result)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (beat_accept) state_next = finish ? OUTPUT : ACCUM;
      ACCUM:   if (finish) state_next = OUTPUT;
      OUTPUT:  if (activation_ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Hitting MAX_CHUNKS without a last flag closes the neuron and latches the error
  always_ff @(posedge clk_in or negedge reset_ni) begin
    if (!reset_ni) begin
      acc                  <= '0;
      chunk_count          <= '0;
      activation_out       <= '0;
      activation_valid_out <= 1'b0;
      chunk_overflow_out   <= 1'b0;
    end else if (beat_accept) begin
      acc         <= acc_next;
      chunk_count <= count_next;
      if (finish) begin
        activation_out       <= sat_result;
        activation_valid_out <= 1'b1;
      end
      if (at_max && !partial_last_in) begin
        chunk_overflow_out <= 1'b1;
      end
    end else if ((state == OUTPUT) && activation_ready_in) begin
      activation_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_accumulate_activate.sv
// Directed bench: table of neurons checked on a ReLU and a pass-through instance,
// plus hand-written backpressure, overflow and reset sequences.
module tb_neuron_accumulate_activate;

  logic        clk_in = 1'b0;
  logic        reset_ni;
  logic [15:0] partial_sum_in;
  logic        partial_valid_in;
  logic        partial_last_in;
  logic [15:0] bias_in;
  logic        activation_ready_in;

  logic        ready_relu, ready_raw;
  logic [15:0] act_relu, act_raw;
  logic        valid_relu, valid_raw;
  logic        ovf_relu, ovf_raw;

  int check_count = 0;
  int error_count = 0;

  typedef struct packed {
    logic [15:0]       bias;
    logic [2:0]        n;
    logic [3:0][15:0]  beats;
    logic [15:0]       exp_relu;
    logic [15:0]       exp_raw;
  } vec_t;

  vec_t vecs [6];

  always #5 clk_in = ~clk_in;

  neuron_accumulate_activate #(.RELU_ENABLE(1)) dut_relu (
    .clk_in              (clk_in),
    .reset_ni            (reset_ni),
    .partial_sum_in      (partial_sum_in),
    .partial_valid_in    (partial_valid_in),
    .partial_last_in     (partial_last_in),
    .partial_ready_out   (ready_relu),
    .bias_in             (bias_in),
    .activation_out      (act_relu),
    .activation_valid_out(valid_relu),
    .activation_ready_in (activation_ready_in),
    .chunk_overflow_out  (ovf_relu)
  );

  neuron_accumulate_activate #(.RELU_ENABLE(0)) dut_raw (
    .clk_in              (clk_in),
    .reset_ni            (reset_ni),
    .partial_sum_in      (partial_sum_in),
    .partial_valid_in    (partial_valid_in),
    .partial_last_in     (partial_last_in),
    .partial_ready_out   (ready_raw),
    .bias_in             (bias_in),
    .activation_out      (act_raw),
    .activation_valid_out(valid_raw),
    .activation_ready_in (activation_ready_in),
    .chunk_overflow_out  (ovf_raw)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic beat(input logic [15:0] bias, input logic [15:0] val, input logic last);
    @(negedge clk_in);
    bias_in          = bias;
    partial_sum_in   = val;
    partial_valid_in = 1'b1;
    partial_last_in  = last;
  endtask

  task automatic releaseOutput(input string name);
    @(negedge clk_in);
    partial_valid_in    = 1'b0;
    partial_last_in     = 1'b0;
    activation_ready_in = 1'b1;
    @(posedge clk_in); #1;
    checkOutput({name, " valid_relu after release"}, 32'(valid_relu), 32'd0);
    checkOutput({name, " valid_raw after release"},  32'(valid_raw),  32'd0);
    checkOutput({name, " ready after release"},      32'(ready_relu), 32'd1);
    @(negedge clk_in);
    activation_ready_in = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    for (int i = 0; i < int'(v.n); i++) begin
      beat(v.bias, v.beats[i], (i == int'(v.n) - 1));
      if (i == int'(v.n) - 1) begin
        checkOutput({name, " valid before last edge"}, 32'(valid_relu), 32'd0);
      end
      @(posedge clk_in); #1;
    end
    checkOutput({name, " valid_relu"}, 32'(valid_relu), 32'd1);
    checkOutput({name, " act_relu"},   32'(act_relu),   32'(v.exp_relu));
    checkOutput({name, " valid_raw"},  32'(valid_raw),  32'd1);
    checkOutput({name, " act_raw"},    32'(act_raw),    32'(v.exp_raw));
    checkOutput({name, " ovf"},        32'(ovf_relu),   32'd0);
    checkOutput({name, " ready low"},  32'(ready_relu), 32'd0);
    releaseOutput(name);
  endtask

  initial begin
    vecs[0] = '{bias: 16'd5,     n: 3'd3, beats: {16'd0, 16'd30, 16'd20, 16'd10},
                exp_relu: 16'd65,    exp_raw: 16'd65};
    vecs[1] = '{bias: 16'd0,     n: 3'd2, beats: {16'd0, 16'd0, 16'h0028, 16'hFF9C},
                exp_relu: 16'd0,     exp_raw: 16'hFFC4};
    vecs[2] = '{bias: 16'h7000,  n: 3'd2, beats: {16'd0, 16'd0, 16'h7000, 16'h7000},
                exp_relu: 16'h7FFF,  exp_raw: 16'h7FFF};
    vecs[3] = '{bias: 16'h9000,  n: 3'd2, beats: {16'd0, 16'd0, 16'h9000, 16'h9000},
                exp_relu: 16'd0,     exp_raw: 16'h8000};
    vecs[4] = '{bias: 16'hFFFD,  n: 3'd1, beats: {16'd0, 16'd0, 16'd0, 16'd3},
                exp_relu: 16'd0,     exp_raw: 16'd0};
    vecs[5] = '{bias: 16'd100,   n: 3'd2, beats: {16'd0, 16'd0, 16'hFF38, 16'd5},
                exp_relu: 16'd0,     exp_raw: 16'hFFA1};

    reset_ni            = 1'b0;
    partial_sum_in      = '0;
    partial_valid_in    = 1'b0;
    partial_last_in     = 1'b0;
    bias_in             = '0;
    activation_ready_in = 1'b0;
    #1;
    checkOutput("reset act",   32'(act_relu),   32'd0);
    checkOutput("reset valid", 32'(valid_relu), 32'd0);
    checkOutput("reset ovf",   32'(ovf_relu),   32'd0);
    checkOutput("reset ready", 32'(ready_relu), 32'd1);
    repeat (2) @(negedge clk_in);
    reset_ni = 1'b1;

    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k], $sformatf("vec%0d", k));
    end

    // Backpressure: output must hold while the upstream keeps pushing beats
    beat(16'd1, 16'd2, 1'b0);
    @(posedge clk_in); #1;
    beat(16'd1, 16'd3, 1'b1);
    @(posedge clk_in); #1;
    checkOutput("hold first valid", 32'(valid_relu), 32'd1);
    for (int c = 0; c < 5; c++) begin
      beat(16'd50, 16'd99, 1'b1);
      @(posedge clk_in); #1;
      checkOutput($sformatf("hold%0d act", c),   32'(act_relu),   32'd6);
      checkOutput($sformatf("hold%0d valid", c), 32'(valid_relu), 32'd1);
      checkOutput($sformatf("hold%0d ready", c), 32'(ready_relu), 32'd0);
    end
    releaseOutput("hold");
    beat(16'd0, 16'd4, 1'b1);
    @(posedge clk_in); #1;
    checkOutput("after hold act", 32'(act_relu), 32'd4);
    releaseOutput("after hold");

    // Sixteen beats with no last flag: forced close plus sticky overflow
    for (int b = 0; b < 16; b++) begin
      beat(16'd0, 16'd1, 1'b0);
      @(posedge clk_in); #1;
      if (b == 14) checkOutput("ovf valid at 15", 32'(valid_relu), 32'd0);
    end
    checkOutput("ovf act",   32'(act_relu),   32'd16);
    checkOutput("ovf valid", 32'(valid_relu), 32'd1);
    checkOutput("ovf flag",  32'(ovf_relu),   32'd1);
    checkOutput("ovf flag raw", 32'(ovf_raw), 32'd1);
    releaseOutput("ovf");
    beat(16'd0, 16'd7, 1'b1);
    @(posedge clk_in); #1;
    checkOutput("ovf sticky act",  32'(act_relu), 32'd7);
    checkOutput("ovf sticky flag", 32'(ovf_relu), 32'd1);
    releaseOutput("ovf sticky");

    // Asynchronous reset mid-neuron discards the partial sum
    beat(16'd0, 16'd50, 1'b0);
    @(posedge clk_in); #1;
    beat(16'd0, 16'd50, 1'b0);
    @(posedge clk_in); #1;
    #2;
    partial_valid_in = 1'b0;
    reset_ni = 1'b0;
    #1;
    checkOutput("mid reset act",   32'(act_relu),   32'd0);
    checkOutput("mid reset valid", 32'(valid_relu), 32'd0);
    checkOutput("mid reset ovf",   32'(ovf_relu),   32'd0);
    checkOutput("mid reset ready", 32'(ready_relu), 32'd1);
    @(negedge clk_in);
    @(negedge clk_in);
    reset_ni = 1'b1;
    beat(16'd0, 16'd7, 1'b1);
    @(posedge clk_in); #1;
    checkOutput("post reset act",   32'(act_relu),   32'd7);
    checkOutput("post reset valid", 32'(valid_relu), 32'd1);
    checkOutput("post reset ovf",   32'(ovf_relu),   32'd0);
    releaseOutput("post reset");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
